fetch_queue: RTL

Instruction queue between the fetch stage and the execute stage of the 16-bit pipelined CPU. It buffers up to DEPTH fetched {pc, instr} pairs so fetch can run ahead while execute stalls on data hazards. It flushes all entries in one cycle on a control-flow redirect. It replaces the direct fetch-to-execute instruction wire.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_queue.sv | 78 +++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit pipelined CPU.
// Holds the fetch/execute bundle and pipeline constants.
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // Execute substitutes this whenever the queue head is not valid.
  localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and execute.
// Lets fetch run ahead during execute stalls; flushes in one cycle on redirect.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_pc,
  input  logic [WORD_W-1:0]        in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WORD_W-1:0]        out_pc,
  output logic [WORD_W-1:0]        out_instr,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t      r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_cnt;

  logic              w_push;
  logic              w_pop;
  fetch_entry_t      w_entry;
  fetch_entry_t      w_head;

  // Full blocks push even with a same-cycle pop: no out_ready->in_ready path.
  assign in_ready  = (r_cnt != FULL);
  assign out_valid = (r_cnt != '0);
  assign count     = r_cnt;

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  assign w_entry.pc    = in_pc;
  assign w_entry.instr = in_instr;

  assign w_head    = r_mem[r_rd_ptr];
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
